ap_ctrl_sequencer: RTL and testbench

//  Synthesizable initiator for the HLS block-level handshake (ap_start/ap_ready/ap_done/ap_continue).
//  - Drives a DUT top through a programmed number of transactions.
//  - Applies programmable ap_continue back-pressure (ap_ctrl_chain style).
//  - Measures per-transaction latency (start accept -> done consume).
//  - Raises finish when the run is complete.
//  - Sits between the test harness and the DUT top; the dataflow/status monitors observe the same wires.

---
 rtl/ap_ctrl_seq_pkg.sv | 15 +
 rtl/ap_ctrl_sequencer_if.sv | 23 ++
 rtl/ap_ts_fifo.sv | 45 ++++
 rtl/ap_ctrl_sequencer.sv | 149 ++++++++++++++
 tb/tb_ap_ctrl_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ap_ctrl_seq_pkg.sv
// Shared types and default sizing for the HLS block-level handshake sequencer.
package ap_ctrl_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_e;

    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int DEF_CNT_W           = 32;
    localparam int DEF_TXN_W           = 16;

endpackage

// File: rtl/ap_ctrl_sequencer_if.sv
// ap_ctrl_chain handshake wires between the sequencer (master) and the HLS top (slave).
interface ap_ctrl_sequencer_if;

    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;

    modport master (
        output ap_start,
        output ap_continue,
        input  ap_ready,
        input  ap_done
    );

    modport slave (
        input  ap_start,
        input  ap_continue,
        output ap_ready,
        output ap_done
    );

endinterface

// File: rtl/ap_ts_fifo.sv
// Start-timestamp FIFO: circular buffer with show-ahead read and an extra pointer
// bit so full and empty can be told apart without a separate count.
module ap_ts_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// Drives an HLS top through a programmed number of ap_ctrl_chain transactions,
// applies ap_continue back-pressure and reports per-transaction latency.
module ap_ctrl_sequencer
    import ap_ctrl_seq_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int TXN_W           = DEF_TXN_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cfg_go,
    input  logic [TXN_W-1:0]     cfg_num_txn,
    input  logic [7:0]           cfg_cont_stall,
    ap_ctrl_sequencer_if.master  hs,
    output logic                 lat_valid,
    output logic [CNT_W-1:0]     lat_value,
    output logic [TXN_W-1:0]     lat_index,
    output logic                 busy,
    output logic                 finish,
    output logic                 err_orphan_done
);

    localparam logic [TXN_W-1:0] MAX_INFLIGHT = TXN_W'(MAX_OUTSTANDING);

    state_e           state_q, state_d;
    logic             start_q, start_d;
    logic [TXN_W-1:0] num_q, issued_q, completed_q;
    logic [TXN_W-1:0] issued_nx, completed_nx, inflight_nx;
    logic [7:0]       stall_cfg_q, stall_cnt_q;
    logic [CNT_W-1:0] cyc_q, head;
    logic             go, accept, consume, bypass, push, pop, retire, orphan;
    logic             fifo_full, fifo_empty;

    assign go      = cfg_go && (state_q == IDLE);
    assign accept  = start_q && hs.ap_ready;
    assign consume = hs.ap_done && hs.ap_continue;
    // An accept and done in the same cycle with nothing queued is a zero-latency
    // transaction: it never touches the FIFO.
    assign bypass  = accept && consume && fifo_empty;
    assign push    = accept && !bypass;
    assign pop     = consume && !fifo_empty;
    assign retire  = pop || bypass;
    assign orphan  = consume && fifo_empty && !accept;

    assign issued_nx    = issued_q + TXN_W'(accept);
    assign completed_nx = completed_q + TXN_W'(retire);
    assign inflight_nx  = issued_nx - completed_nx;

    assign busy           = (state_q == ISSUE) || (state_q == DRAIN);
    assign finish         = (state_q == FIN);
    assign hs.ap_start    = start_q;
    assign hs.ap_continue = busy && (stall_cnt_q == 8'd0);

    ap_ts_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (CNT_W)
    ) u_ts_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (cyc_q),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ap_start is decided one cycle ahead so it stays high until accepted and
    // never rises while the timestamp FIFO would be full.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_go) begin
                    state_d = (cfg_num_txn == '0) ? FIN : ISSUE;
                    start_d = (cfg_num_txn != '0);
                end
            end
            ISSUE: begin
                if (issued_q == num_q) begin
                    state_d = DRAIN;
                end else begin
                    start_d = (issued_nx < num_q) && (inflight_nx < MAX_INFLIGHT);
                end
            end
            DRAIN: begin
                if (completed_q == num_q) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc_q           <= '0;
            num_q           <= '0;
            issued_q        <= '0;
            completed_q     <= '0;
            stall_cfg_q     <= '0;
            stall_cnt_q     <= '0;
            lat_valid       <= 1'b0;
            lat_value       <= '0;
            lat_index       <= '0;
            err_orphan_done <= 1'b0;
        end else begin
            cyc_q     <= cyc_q + 1'b1;
            lat_valid <= retire;
            if (retire) begin
                lat_value <= bypass ? '0 : (cyc_q - head);
                lat_index <= completed_q;
            end
            if (go) begin
                num_q           <= cfg_num_txn;
                stall_cfg_q     <= cfg_cont_stall;
                issued_q        <= '0;
                completed_q     <= '0;
                stall_cnt_q     <= '0;
                err_orphan_done <= 1'b0;
            end else begin
                issued_q    <= issued_nx;
                completed_q <= completed_nx;
                if (consume) begin
                    stall_cnt_q <= stall_cfg_q;
                end else if (stall_cnt_q != 8'd0) begin
                    stall_cnt_q <= stall_cnt_q - 8'd1;
                end
                if (orphan) begin
                    err_orphan_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Directed bench for ap_ctrl_sequencer with a configurable HLS-top responder model.
module tb_ap_ctrl_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_go = 1'b0;
    logic [15:0] cfg_num_txn = '0;
    logic [7:0]  cfg_cont_stall = '0;
    logic        lat_valid;
    logic [31:0] lat_value;
    logic [15:0] lat_index;
    logic        busy;
    logic        finish;
    logic        err_orphan_done;

    ap_ctrl_sequencer_if hs ();

    ap_ctrl_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .cfg_go          (cfg_go),
        .cfg_num_txn     (cfg_num_txn),
        .cfg_cont_stall  (cfg_cont_stall),
        .hs              (hs),
        .lat_valid       (lat_valid),
        .lat_value       (lat_value),
        .lat_index       (lat_index),
        .busy            (busy),
        .finish          (finish),
        .err_orphan_done (err_orphan_done)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int tcyc     = 0;

    int  resp_lat    = 1;
    bit  resp_comb   = 1'b0;
    bit  resp_ready  = 1'b1;
    bit  inject_done = 1'b0;
    int  rq[$];
    int  max_q = 0;

    int  lat_log[$];
    int  idx_log[$];
    int  tv_log[$];
    int  fin_cnt = 0;
    int  start_cnt = 0;

    always @(posedge clock) tcyc++;

    // Responder: a done becomes visible resp_lat cycles after its accept and is
    // held until consumed; in combinational mode done follows the accept itself.
    always @(negedge clock) begin
        if (!reset) begin
            rq.delete();
            hs.ap_done  = 1'b0;
            hs.ap_ready = resp_ready;
        end else begin
            hs.ap_ready = resp_ready;
            if (resp_comb) begin
                hs.ap_done = hs.ap_start && hs.ap_ready;
            end else begin
                hs.ap_done = inject_done || ((rq.size() > 0) && (tcyc >= rq[0] + resp_lat));
            end
            if (hs.ap_done && hs.ap_continue && rq.size() > 0) begin
                void'(rq.pop_front());
            end
            if (hs.ap_start && hs.ap_ready && !resp_comb) begin
                rq.push_back(tcyc);
            end
            if (rq.size() > max_q) max_q = rq.size();
        end
    end

    always @(negedge clock) begin
        if (lat_valid) begin
            lat_log.push_back(int'(lat_value));
            idx_log.push_back(int'(lat_index));
            tv_log.push_back(tcyc);
        end
        if (finish) fin_cnt++;
        if (hs.ap_start) start_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int n, input int stall, input int lat, input bit comb, input bit ready);
        @(negedge clock);
        lat_log.delete();
        idx_log.delete();
        tv_log.delete();
        fin_cnt        = 0;
        start_cnt      = 0;
        max_q          = 0;
        resp_lat       = lat;
        resp_comb      = comb;
        resp_ready     = ready;
        cfg_num_txn    = 16'(n);
        cfg_cont_stall = 8'(stall);
        cfg_go         = 1'b1;
        @(negedge clock);
        cfg_go = 1'b0;
    endtask

    task automatic waitFinish(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (finish) seen = 1'b1;
        end
        checkOutput({tag, "_finished"}, 64'(seen), 64'd1);
        @(negedge clock);
    endtask

    task automatic checkLatencies(input string tag, input int n, input int exp_lat);
        checkOutput({tag, "_count"}, 64'(lat_log.size()), 64'(n));
        for (int i = 0; i < lat_log.size(); i++) begin
            checkOutput($sformatf("%s_lat%0d", tag, i), 64'(lat_log[i]), 64'(exp_lat));
            checkOutput($sformatf("%s_idx%0d", tag, i), 64'(idx_log[i]), 64'(i));
        end
    endtask

    initial begin
        hs.ap_ready = 1'b0;
        hs.ap_done  = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_outs", 64'({hs.ap_start, hs.ap_continue, lat_valid, finish, err_orphan_done}), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("[TB] latency 5, three transactions");
        applyStimulus(3, 0, 5, 1'b0, 1'b1);
        checkOutput("t1_busy_run", 64'(busy), 64'd1);
        waitFinish("t1", 100);
        checkLatencies("t1", 3, 5);
        checkOutput("t1_fin_cnt", 64'(fin_cnt), 64'd1);
        checkOutput("t1_busy_after", 64'(busy), 64'd0);
        checkOutput("t1_finish_low", 64'(finish), 64'd0);

        $display("[TB] zero-transaction run");
        applyStimulus(0, 0, 5, 1'b0, 1'b1);
        checkOutput("t2_finish", 64'(finish), 64'd1);
        checkOutput("t2_busy", 64'(busy), 64'd0);
        @(negedge clock);
        checkOutput("t2_finish_pulse", 64'(finish), 64'd0);
        repeat (2) @(negedge clock);
        checkOutput("t2_no_start", 64'(start_cnt), 64'd0);
        checkOutput("t2_no_lat", 64'(lat_log.size()), 64'd0);

        $display("[TB] pipelined responder, latency 10, eight transactions");
        applyStimulus(8, 0, 10, 1'b0, 1'b1);
        waitFinish("t3", 200);
        checkLatencies("t3", 8, 10);
        checkOutput("t3_max_inflight", 64'(max_q), 64'd4);

        // Latency 1 with 3-cycle stalls: consumes land 4 cycles apart, giving 1,4,7.
        $display("[TB] continue stall of 3");
        applyStimulus(3, 3, 1, 1'b0, 1'b1);
        waitFinish("t4", 200);
        checkOutput("t4_count", 64'(lat_log.size()), 64'd3);
        if (lat_log.size() == 3) begin
            checkOutput("t4_lat0", 64'(lat_log[0]), 64'd1);
            checkOutput("t4_lat1", 64'(lat_log[1]), 64'd4);
            checkOutput("t4_lat2", 64'(lat_log[2]), 64'd7);
            checkOutput("t4_gap0", 64'(tv_log[1] - tv_log[0]), 64'd4);
            checkOutput("t4_gap1", 64'(tv_log[2] - tv_log[1]), 64'd4);
        end

        $display("[TB] combinational responder");
        applyStimulus(2, 0, 0, 1'b1, 1'b1);
        waitFinish("t5", 100);
        checkLatencies("t5", 2, 0);
        checkOutput("t5_no_orphan", 64'(err_orphan_done), 64'd0);

        $display("[TB] spurious done during issue");
        applyStimulus(2, 0, 2, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        checkOutput("t6_err_before", 64'(err_orphan_done), 64'd0);
        @(posedge clock); #1;
        inject_done = 1'b1;
        @(posedge clock); #1;
        inject_done = 1'b0;
        checkOutput("t6_err_set", 64'(err_orphan_done), 64'd1);
        resp_ready = 1'b1;
        waitFinish("t6", 100);
        checkLatencies("t6", 2, 2);
        checkOutput("t6_err_sticky", 64'(err_orphan_done), 64'd1);

        $display("[TB] reset in drain");
        applyStimulus(2, 0, 20, 1'b0, 1'b1);
        checkOutput("t7_err_cleared", 64'(err_orphan_done), 64'd0);
        repeat (5) @(negedge clock);
        checkOutput("t7_busy_pre", 64'(busy), 64'd1);
        checkOutput("t7_cont_pre", 64'(hs.ap_continue), 64'd1);
        #3 reset = 1'b0;
        #1;
        checkOutput("t7_rst_busy", 64'(busy), 64'd0);
        checkOutput("t7_rst_cont", 64'(hs.ap_continue), 64'd0);
        checkOutput("t7_rst_outs", 64'({hs.ap_start, lat_valid, finish, err_orphan_done, lat_value, lat_index}), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        applyStimulus(1, 0, 3, 1'b0, 1'b1);
        waitFinish("t7", 100);
        checkLatencies("t7", 1, 3);
        checkOutput("t7_fin_cnt", 64'(fin_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
